fifo_pop_scheduler: RTL
=======================

Name: fifo_pop_scheduler

Overview:
- Output-side scheduler for the 8x8 switch.
- Shares one egress port between N source FIFOs (128x32 queues) using round-robin with bounded bursts.
- Drives each FIFO's pop, takes the FIFO's combinational head word (`data_out`), and presents one registered word per cycle on a valid/ready egress interface.
- Sits between the per-output bank of FIFOs and the output port logic.

Parameters:
- N, 8, number of source FIFOs (2..8).
- W, 32, payload width.
- SRC_W, 3, width of the source index; must satisfy 2^SRC_W >= N.
- MAX_BURST, 4, maximum words popped from one source per grant (1..16).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- fifo_empty  input  N  per-source empty flag; bit i from FIFO i.
- fifo_data  input  N*W  concatenated FIFO head words; FIFO i in bits [i*W +: W].
- fifo_pop  output  N  per-source pop; at most one bit high per cycle.
- out_valid  output  1  egress word valid.
- out_ready  input  1  egress sink accepts the word.
- out_data  output  W  egress payload.
- out_src  output  SRC_W  index of the FIFO that supplied out_data.
- busy  output  1  high while a grant is held (state BURST).

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values:
  - state = IDLE, out_valid = 0, out_data = 0, out_src = 0.
  - fifo_pop = 0, busy = 0, burst_cnt = 0.
  - last_grant = N-1, so the first search starts at source 0.
- Register load enable: can_load = !out_valid || out_ready.
- IDLE state:
  - Searches fifo_empty in round-robin order last_grant+1, last_grant+2, ... (mod N).
  - Takes the first source with fifo_empty = 0.
  - If one is found: grant <= index, last_grant <= index, burst_cnt <= 0, state <= BURST.
  - If none is found: stay in IDLE.
  - No pop is issued in IDLE. Grant setup costs one bubble cycle.
- BURST state, pop rule:
  - fifo_pop[grant] = fifo_empty[grant] == 0 && can_load. This is combinational; all other pop bits are 0.
- BURST state, on a pop:
  - out_data <= fifo_data[grant], out_src <= grant, out_valid <= 1.
  - burst_cnt <= burst_cnt + 1.
  - Latency: a pop in cycle t gives out_valid = 1 in cycle t+1.
- BURST state exits:
  - A pop with burst_cnt == MAX_BURST-1 goes to IDLE.
  - fifo_empty[grant] == 1 goes to IDLE with no pop. This is a source drained mid-burst; the empty flag is observed the cycle after the last pop.
- BURST state, stall (!can_load):
  - out_data and out_src hold, no pop, burst_cnt holds, state stays BURST.
  - The stall does not time out.
- Output register:
  - If out_valid && out_ready and no new pop, out_valid <= 0.
  - A new pop in the same cycle as acceptance reloads the register, giving back-to-back words with no bubble.
- Safety:
  - The block never pops an empty FIFO.
  - At most one pop per cycle.
  - No word is dropped or duplicated under any out_ready pattern.
- Reset asserted mid-burst:
  - All state returns to reset values on the next edge; any in-flight out_data is discarded.
  - FIFO contents are untouched. The FIFO's reset is separate.
- Index arithmetic:
  - Round-robin wrap is modulo N. For N < 2^SRC_W, unused indices are never granted.
  - burst_cnt width is 4 bits.
- Priority: strict round-robin only; no weighting. A newly non-empty source waits at most (N-1) grants of MAX_BURST words.

Optional Feature:
- Macro: FIFO_POP_SCHED_STATS_EN.
- When defined:
  - Adds one 16-bit saturating word counter per source, incremented on each fifo_pop[i].
  - Counters hold at 16'hFFFF and clear on reset.
  - Adds input stat_sel (SRC_W) and output stat_cnt (16), where stat_cnt = counter[stat_sel] combinationally.
  - An out-of-range stat_sel returns 0.
- When undefined: no counters and no stat_sel/stat_cnt ports. Behaviour is otherwise identical.

Test Plan:
- Reset: hold reset 2 cycles with all FIFOs non-empty -> out_valid = 0 and fifo_pop = 0 throughout. First grant is source 0, and busy rises on the edge after reset deasserts.
- Single source: FIFO 3 holds 32'hA5A5_0001 and 32'hA5A5_0002; out_ready = 1; MAX_BURST = 4 -> out_src = 3 with the two words in order on consecutive cycles, then empty detected, then IDLE; exactly 2 pops.
- Full fairness: all 8 FIFOs hold 10 words; out_ready = 1; MAX_BURST = 4 -> out_src sequence 0x4, 1x4, ..., 7x4, 0x4, with one bubble between bursts. Total of 80 words delivered with no loss.
- Backpressure: during a burst from source 5, drop out_ready for 5 cycles -> out_data stable, fifo_pop = 0 for all 5 cycles; on release the next word follows with no bubble and nothing is lost.
- Round-robin pointer: last_grant = 2 and only FIFOs 1 and 6 are non-empty -> next grant is 6, then 1.
- Reset mid-burst: assert reset while out_valid = 1 from source 4 -> next cycle out_valid = 0 and busy = 0; after release, the first grant goes to the lowest-indexed non-empty source at or after 0.

Source files
------------

// File: rtl/fifo_pop_scheduler.sv
// fifo_pop_scheduler: egress-side round-robin pop scheduler for one
// switch output. It pops the N source FIFOs in bounded bursts and drives a
// single registered valid/ready egress stream.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   fifo_empty [N]        per-source empty flags
//   fifo_data  [N*W]      per-source combinational head words (FIFO i at i*W)
//   fifo_pop   [N]        per-source pop strobe, at most one bit set
//   out_valid/out_ready   egress handshake
//   out_data   [W]        egress payload
//   out_src    [SRC_W]    source index of out_data
//   busy                  a grant is held (BURST state)
//
// Optional build macro FIFO_POP_SCHED_STATS_EN adds per-source 16-bit
// saturating pop counters, read through stat_sel / stat_cnt.

module fifo_pop_scheduler #(
    parameter int N         = 8,
    parameter int W         = 32,
    parameter int SRC_W     = 3,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     fifo_empty,
    input  logic [N*W-1:0]   fifo_data,
    output logic [N-1:0]     fifo_pop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [SRC_W-1:0] out_src,
    output logic             busy
`ifdef FIFO_POP_SCHED_STATS_EN
    ,
    input  logic [SRC_W-1:0] stat_sel,
    output logic [15:0]      stat_cnt
`endif
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [3:0]       LAST_BEAT = 4'(MAX_BURST - 1);
    localparam logic [N-1:0]     POP_ONE   = N'(1);
    localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(N - 1);

    logic [0:0]       state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] last_grant_q, last_grant_d;
    logic [3:0]       burst_cnt_q, burst_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;

    logic [W-1:0]     head_data [N];
    logic             can_load;
    logic             pop_en;
    logic             found;
    logic [SRC_W-1:0] found_idx;
    logic [SRC_W-1:0] cand;

    // Unpack the flat head-word bus so the granted word is a plain index.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            head_data[i] = fifo_data[i*W +: W];
        end
    end

    // The output register may take a new word when it is empty or being
    // drained this cycle; that keeps bursts back-to-back under ready = 1.
    assign can_load = !out_valid_q || out_ready;

    // Pops are suppressed while reset is asserted so that a reset cycle
    // never consumes FIFO words that the cleared register would lose.
    assign pop_en = !reset
                 && (state_q == BURST)
                 && !fifo_empty[grant_q]
                 && can_load;

    assign fifo_pop = pop_en ? (POP_ONE << grant_q) : '0;

    // Round-robin search starting just after the last granted source.
    // The first hit in search order wins, so later hits are ignored.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = SRC_W'((int'(last_grant_q) + k) % N);
            if (!found && !fifo_empty[cand]) begin
                found     = 1'b1;
                found_idx = cand;
            end
        end
    end

    // Grant / burst control.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d      = found_idx;
                    last_grant_d = found_idx;
                    burst_cnt_d  = '0;
                    state_d      = BURST;
                end
            end
            BURST: begin
                // A drained source ends the burst early; a stall
                // (no pop, source not empty) simply holds everything.
                if (fifo_empty[grant_q]) begin
                    state_d = IDLE;
                end else if (pop_en) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (burst_cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Egress register: reload on a pop, otherwise clear once accepted.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (pop_en) begin
            out_valid_d = 1'b1;
            out_data_d  = head_data[grant_q];
            out_src_d   = grant_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_SRC;
            burst_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == BURST);

`ifdef FIFO_POP_SCHED_STATS_EN
    logic [15:0] stat_q [N];

    // One saturating word counter per source.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (fifo_pop[i] && (stat_q[i] != 16'hFFFF)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    // Indices at or beyond N name no source and read as zero.
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(stat_sel) == i) begin
                stat_cnt = stat_q[i];
            end
        end
    end
`endif

endmodule
